fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter and occupancy tracker for the shared `fifo` block. It lets N producers share the FIFO's single write port and gates the consumer's read requests so the FIFO is never over-written or under-read. The FIFO exposes no full/empty flags, so this block keeps the authoritative occupancy count. It sits between the producers/consumer and the `fifo` instance, driving `fifo.wr`, `fifo.wr_data` and `fifo.rd`; `fifo.rd_data` goes straight to the consumer and does not pass through this block.

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared FIFO that has no status flags.
// It registers the granted word toward the FIFO, tracks committed occupancy and gates consumer reads.
module fifo_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int ADDR_W = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [N-1:0]                  req_i,
    input  logic [N*DATA_W-1:0]           req_data_i,
    output logic [N-1:0]                  gnt_o,
    input  logic                          rd_req_i,
    output logic                          rd_ack_o,
    output logic                          fifo_wr_o,
    output logic [DATA_W-1:0]             fifo_wr_data_o,
    output logic                          fifo_rd_o,
    output logic [ADDR_W:0]               count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(N)-1:0]          last_gnt_o
);
    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0] fifo_wr_data_q, fifo_wr_data_d;

    logic [CNT_W-1:0]  occ_s;
    logic              grant_en_s;
    logic              found_s;
    logic [PTR_W-1:0]  win_s;
    logic [PTR_W:0]    cand_s;
    logic [N-1:0]      gnt_s;
    logic              rd_ack_s;

    // A word sitting in the output register already owns a slot, so it counts against the grant.
    assign occ_s      = count_q + {{ADDR_W{1'b0}}, fifo_wr_q};
    assign grant_en_s = (occ_s < DEPTH);

    // Find the first requester at or after the round-robin pointer, wrapping at N.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        cand_s  = {(PTR_W+1){1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_q} + (PTR_W+1)'(k);
            cand_s = (cand_s >= (PTR_W+1)'(N)) ? (cand_s - (PTR_W+1)'(N)) : cand_s;
            if (!found_s && req_i[cand_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant and read acknowledge are forced low while reset is asserted.
    always_comb begin
        gnt_s = {N{1'b0}};
        if (reset_ni && grant_en_s && found_s) begin
            gnt_s[win_s] = 1'b1;
        end else begin
            gnt_s = {N{1'b0}};
        end
        rd_ack_s = reset_ni & rd_req_i & (count_q != {CNT_W{1'b0}});
    end

    // Next-state for pointer, write pipeline and occupancy.
    always_comb begin
        ptr_d          = ptr_q;
        last_gnt_d     = last_gnt_q;
        fifo_wr_d      = 1'b0;
        fifo_wr_data_d = fifo_wr_data_q;
        if (gnt_s != {N{1'b0}}) begin
            ptr_d          = (win_s == PTR_W'(N - 1)) ? {PTR_W{1'b0}} : (win_s + PTR_W'(1));
            last_gnt_d     = win_s;
            fifo_wr_d      = 1'b1;
            fifo_wr_data_d = req_data_i[win_s*DATA_W +: DATA_W];
        end else begin
            fifo_wr_d      = 1'b0;
        end
        count_d = count_q + {{ADDR_W{1'b0}}, fifo_wr_q} - {{ADDR_W{1'b0}}, rd_ack_s};
    end

    // State registers; reset also drops a pending write immediately.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q          <= {PTR_W{1'b0}};
            last_gnt_q     <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            fifo_wr_q      <= 1'b0;
            fifo_wr_data_q <= {DATA_W{1'b0}};
        end else begin
            ptr_q          <= ptr_d;
            last_gnt_q     <= last_gnt_d;
            count_q        <= count_d;
            fifo_wr_q      <= fifo_wr_d;
            fifo_wr_data_q <= fifo_wr_data_d;
        end
    end

    assign gnt_o          = gnt_s;
    assign rd_ack_o       = rd_ack_s;
    assign fifo_rd_o      = rd_ack_s;
    assign fifo_wr_o      = fifo_wr_q;
    assign fifo_wr_data_o = fifo_wr_data_q;
    assign count_o        = count_q;
    assign full_o         = (occ_s == DEPTH);
    assign empty_o        = (count_q == {CNT_W{1'b0}});
    assign last_gnt_o     = last_gnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an occupancy/round-robin model.
module tb_fifo_wr_arbiter;
    localparam int NP    = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         rd_req;
    logic         rd_ack;
    logic         fifo_wr;
    logic [31:0]  fifo_wr_data;
    logic         fifo_rd;
    logic [2:0]   count;
    logic         full;
    logic         empty;
    logic [1:0]   last_gnt;

    int errors = 0;
    int checks = 0;

    // model state: committed words, pending registered word, pointer, last grant
    int          m_count = 0;
    int          m_ptr   = 0;
    int          m_last  = 0;
    bit          m_wr    = 1'b0;
    logic [31:0] m_wr_data = 32'h0;
    logic [3:0]  m_gnt_prev = 4'b0;
    int          rst_left = 0;

    fifo_wr_arbiter #(.DATA_W(32), .N(NP), .ADDR_W(2)) dut (
        .clk_i(clk), .reset_ni(reset_n), .req_i(req), .req_data_i(req_data),
        .gnt_o(gnt), .rd_req_i(rd_req), .rd_ack_o(rd_ack), .fifo_wr_o(fifo_wr),
        .fifo_wr_data_o(fifo_wr_data), .fifo_rd_o(fifo_rd), .count_o(count),
        .full_o(full), .empty_o(empty), .last_gnt_o(last_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model, then advance the model by one edge.
    always begin
        int         win;
        logic [3:0] e_gnt;
        bit         e_rd;
        @(negedge clk);
        #1;
        if (!reset_n) begin
            m_count = 0; m_ptr = 0; m_last = 0; m_wr = 1'b0; m_wr_data = 32'h0;
        end
        win = -1;
        if (reset_n && (m_count + int'(m_wr) < DEPTH)) begin
            for (int k = 0; k < NP; k++) begin
                if (win < 0 && req[(m_ptr + k) % NP]) win = (m_ptr + k) % NP;
            end
        end
        e_gnt = 4'b0;
        if (win >= 0) e_gnt[win] = 1'b1;
        e_rd = reset_n && rd_req && (m_count > 0);
        chk("gnt", gnt, e_gnt);
        chk("rd_ack", rd_ack, e_rd);
        chk("fifo_rd", fifo_rd, e_rd);
        chk("fifo_wr", fifo_wr, m_wr);
        chk("fifo_wr_data", fifo_wr_data, m_wr_data);
        chk("count", count, m_count);
        chk("full", full, (m_count + int'(m_wr)) == DEPTH);
        chk("empty", empty, m_count == 0);
        chk("last_gnt", last_gnt, m_last);
        if (reset_n) begin
            m_count = m_count + int'(m_wr) - int'(e_rd);
            if (win >= 0) begin
                m_wr      = 1'b1;
                m_wr_data = req_data[win*32 +: 32];
                m_ptr     = (win + 1) % NP;
                m_last    = win;
            end else begin
                m_wr = 1'b0;
            end
        end
        m_gnt_prev = e_gnt;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0; req = 4'b0; rd_req = 1'b0;
        look();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 4'b1111;
        rd_req   = 1'b1;
        req_data = {32'h3, 32'h2, 32'h1, 32'h0};
        look();
        look();
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_rd_ack", rd_ack, 1'b0);
        chk("rst_fifo_wr", fifo_wr, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);

        // single producer, read attempted before commit
        tick(); reset_n = 1'b1; req = 4'b0; rd_req = 1'b0;
        tick(); req = 4'b0001; req_data[31:0] = 32'hdeadbeef;
        look(); chk("t2_gnt", gnt, 4'b0001);
        tick(); req = 4'b0; rd_req = 1'b1;
        look(); chk("t2_wr", fifo_wr, 1'b1); chk("t2_data", fifo_wr_data, 32'hdeadbeef);
        chk("t2_early_rd", rd_ack, 1'b0);
        tick(); rd_req = 1'b0;
        look(); chk("t2_count", count, 3'd1);
        tick(); rd_req = 1'b1;
        look(); chk("t2_rd", rd_ack, 1'b1);
        tick(); rd_req = 1'b0;
        look(); chk("t2_empty", empty, 1'b1);

        // all producers fill to full
        do_reset();
        req = 4'b1111; req_data = {32'h3, 32'h2, 32'h1, 32'h0};
        look(); chk("t3_g0", gnt, 4'b0001);
        tick(); look(); chk("t3_g1", gnt, 4'b0010);
        tick(); look(); chk("t3_g2", gnt, 4'b0100);
        tick(); look(); chk("t3_g3", gnt, 4'b1000);
        tick(); look(); chk("t3_no5", gnt, 4'b0); chk("t3_full4", full, 1'b1);
        chk("t3_cnt3", count, 3'd3);
        tick(); look(); chk("t3_hold", gnt, 4'b0); chk("t3_cnt4", count, 3'd4);
        chk("t3_full", full, 1'b1);

        // round robin from pointer 2
        do_reset();
        req = 4'b0011; rd_req = 1'b1;
        look(); chk("t4_g0", gnt, 4'b0001);
        tick(); req = 4'b0010;
        look(); chk("t4_g1", gnt, 4'b0010);
        tick(); req = 4'b1011;
        look(); chk("t4_g3", gnt, 4'b1000); chk("t4_rd", rd_ack, 1'b1);
        tick(); look(); chk("t4_g0b", gnt, 4'b0001);
        tick(); look(); chk("t4_g1b", gnt, 4'b0010);
        tick(); req = 4'b0;
        look(); chk("t4_last", last_gnt, 2'd1);

        // simultaneous read and commit, then drain
        do_reset();
        req = 4'b0001; rd_req = 1'b0;
        tick(); req = 4'b0010;
        tick(); req = 4'b0100;
        tick(); req = 4'b0; rd_req = 1'b1;
        look(); chk("t5_ack", rd_ack, 1'b1); chk("t5_cnt", count, 3'd2);
        chk("t5_wr", fifo_wr, 1'b1);
        tick(); look(); chk("t5_cnt_same", count, 3'd2); chk("t5_d1", rd_ack, 1'b1);
        tick(); look(); chk("t5_d2", rd_ack, 1'b1);
        tick(); look(); chk("t5_d3", rd_ack, 1'b0); chk("t5_empty", empty, 1'b1);
        chk("t5_cnt0", count, 3'd0);
        tick(); rd_req = 1'b0;

        // reset in the middle of a registered write
        tick(); req = 4'b1111;
        tick(); req = 4'b0;
        look(); chk("t6_wr", fifo_wr, 1'b1);
        #1 reset_n = 1'b0;
        #1 chk("t6_wr_clr", fifo_wr, 1'b0); chk("t6_cnt", count, 3'd0);
        tick(); req = 4'b1111; rd_req = 1'b1;
        look(); chk("t6_rst_gnt", gnt, 4'b0);
        tick(); reset_n = 1'b1; rd_req = 1'b0;
        look(); chk("t6_ptr0", gnt, 4'b0001);

        // randomized traffic with legal producer handshakes and occasional resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 299) == 0) rst_left = 2;
            if (rst_left > 0) begin
                reset_n = 1'b0;
                rst_left--;
            end else begin
                reset_n = 1'b1;
            end
            for (int i = 0; i < NP; i++) begin
                if (req[i] && m_gnt_prev[i]) begin
                    if ($urandom_range(0, 1) == 1) req_data[i*32 +: 32] = $urandom;
                    else req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    req_data[i*32 +: 32] = $urandom;
                end
            end
            rd_req = ($urandom_range(0, 2) == 0);
        end
        look();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
